vga_pattern_anim: RTL and testbench
===================================

# vga_pattern_anim

Animated test-pattern generator placed directly downstream of the `vga` timing generator and upstream of the board pins. It consumes the generator's `column`/`row`/`visible`/`hsync`/`vsync` stream and produces registered 4-bit RGB plus sync signals delayed to match the pixel pipeline. Per frame, it scrolls an 8-colour bar pattern horizontally and keeps a frame count. A compile-time option adds a bouncing box for motion and tearing checks.

## Interface
- `H_VISIBLE`, 640: visible columns.
- `V_VISIBLE`, 480: visible rows.
- `SPEED`, 1: scroll pixels added to the offset per frame; valid range 0..63.
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i` input 1: pixel clock, the same clock as `vga`.
- `reset_i` input 1: synchronous, active-high reset.
- `pause_i` input 1: freezes scroll offset and box motion.
- `visible_i` input 1: pixel is in the active area.
- `hsync_i` input 1: horizontal sync, active-low.
- `vsync_i` input 1: vertical sync, active-low.
- `column_i` input 10: current column.
- `row_i` input 10: current row.
- `red_o` output 4: pixel red.
- `green_o` output 4: pixel green.
- `blue_o` output 4: pixel blue.
- `hsync_o` output 1: `hsync_i` delayed by 2 cycles.
- `vsync_o` output 1: `vsync_i` delayed by 2 cycles.
- `visible_o` output 1: `visible_i` delayed by 2 cycles.
- `frame_o` output 8: frame counter.

## Operation
- **Frame tick:** `vs_prev` is registered each cycle (reset value 1). Tick = `vs_prev==1 && vsync_i==0`, i.e. the falling edge of vsync.
- **Frame counter:** on a tick, `frame_o` increments, wrapping 255→0. It is independent of `pause_i`.
- **Scroll offset:** 10-bit `offset`. On a tick with `pause_i==0`: `offset <= offset + SPEED`, modulo 1024.
- **Pipeline stage 1 (registered):**
  - `sum = column_i + offset`, modulo 1024.
  - `border = (column_i==0 || column_i==H_VISIBLE-1 || row_i==0 || row_i==V_VISIBLE-1)`.
  - `box_hit` (when the box feature is built in).
  - `visible_i`, `hsync_i`, `vsync_i`.
- **Pipeline stage 2 (registered outputs):**
  - If delayed visible==0: RGB = 0,0,0.
  - Else if `border`: F,F,F.
  - Else if `box_hit`: F,F,0.
  - Else bar colour: `bar = sum[8:6]`; `red_o={4{bar[0]}}`, `green_o={4{bar[1]}}`, `blue_o={4{bar[2]}}`.
- **Bar geometry:** bars are 64 px wide and repeat every 512 px.
- **Reset values:** RGB 0, `hsync_o`=1, `vsync_o`=1, `visible_o`=0, `frame_o`=0, `offset`=0. All pipeline sync registers reset to 1; pipeline visible registers reset to 0.
- **Reset mid-frame:** everything returns to its reset value on the next edge. Output resumes 2 cycles after `reset_i` deasserts, with `offset`=0.

## Timing
- Latency from `column_i`/`row_i`/sync inputs to all outputs is exactly 2 cycles. Syncs and colour stay aligned.
- Offset and box updates take effect on the cycle after the tick. Ticks occur only during vertical blanking, so a visible frame is never split.
- If a tick coincides with `pause_i`=1, the frame counter advances and the offset holds.
- `SPEED=0` gives a static pattern.

## Configuration
- Macro: `VGA_PATTERN_ANIM_BOX_EN`.
- **Defined:** a 16×16 yellow box is drawn.
  - Position: `box_x` (reset 0), `box_y` (reset 0).
  - Direction: `dir_x`, `dir_y`, both reset to +.
  - `box_hit = column_i - box_x < 16 && row_i - box_y < 16`, using unsigned 10-bit compare.
  - Per axis, on a tick with `pause_i`=0:
    - Moving + and at max (`H_VISIBLE-16` or `V_VISIBLE-16`): flip to − and step −1.
    - Moving − and at 0: flip to + and step +1.
    - Otherwise step ±1.
  - Box bounds are therefore [0, 624] × [0, 464].
- **Undefined:** no box registers exist, `box_hit`≡0, and output is bars plus border only.

## Test plan
- **Reset:** hold `reset_i` high for 3 cycles → RGB=0, `hsync_o`=`vsync_o`=1, `visible_o`=0, `frame_o`=0.
- **Static bars and latency:** `offset`=0, drive visible, column 100, row 100 → exactly 2 cycles later RGB = F,0,0 (bar 1). Column 0 → F,F,F (border). `visible_i`=0 → 0,0,0.
- **Scroll:** `SPEED`=1, 3 vsync falling edges → `frame_o`=3, `offset`=3. Column 61, row 100 → F,0,0.
- **Pause:** `pause_i`=1 across 2 ticks → `frame_o` +2, `offset` unchanged, box position unchanged.
- **Wrap:** `SPEED`=63, 17 ticks → `offset`=1071 mod 1024 = 47. After 256 ticks, `frame_o` returns to 0.
- **Box (macro defined):** 624 ticks → `box_x`=624. The next tick → `box_x`=623 with `dir_x`=−. Pixel (630,200) at `box_x`=624, `box_y`=190 → F,F,0.

Source files
------------

// File: rtl/vga_pattern_anim.sv
// vga_pattern_anim
//
// Animated test-pattern generator. It sits between the vga timing generator
// and the board pins. It draws eight scrolling colour bars, each 64 px wide and
// repeating every 512 px, with a white one-pixel border. Every output, including
// the syncs, is delayed by exactly 2 cycles so that colour and sync stay aligned.
//
// Optional feature: define VGA_PATTERN_ANIM_BOX_EN to add a bouncing 16x16
// yellow box, used for motion and tearing checks.
//
// Parameters:
//   H_VISIBLE  visible columns
//   V_VISIBLE  visible rows
//   SPEED      scroll pixels added to the offset per frame (0..63)
//
// Ports:
//   clk_i      pixel clock (same clock as the vga generator)
//   reset_i    synchronous, active-high reset
//   pause_i    freezes the scroll offset and the box motion
//   visible_i  pixel is in the active area
//   hsync_i    horizontal sync, active-low
//   vsync_i    vertical sync, active-low
//   column_i   current column
//   row_i      current row
//   red_o      pixel red, 4 bits
//   green_o    pixel green, 4 bits
//   blue_o     pixel blue, 4 bits
//   hsync_o    hsync_i delayed by 2 cycles
//   vsync_o    vsync_i delayed by 2 cycles
//   visible_o  visible_i delayed by 2 cycles
//   frame_o    frame counter; advances on each vsync falling edge

module vga_pattern_anim #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned SPEED     = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pause_i,
    input  logic       visible_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [9:0] column_i,
    input  logic [9:0] row_i,
    output logic [3:0] red_o,
    output logic [3:0] green_o,
    output logic [3:0] blue_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic [7:0] frame_o
);

    localparam logic [9:0] ColLast = 10'(H_VISIBLE - 1);
    localparam logic [9:0] RowLast = 10'(V_VISIBLE - 1);
    localparam logic [9:0] Step    = 10'(SPEED);

    // Frame tick: falling edge of vsync. Ticks only occur in vertical blanking,
    // so offset and box updates never split a visible frame.
    logic       vs_prev_q;
    logic       tick;
    logic [9:0] offset_q;

    assign tick = vs_prev_q & ~vsync_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vs_prev_q <= 1'b1;
            frame_o   <= 8'd0;
            offset_q  <= 10'd0;
        end else begin
            vs_prev_q <= vsync_i;
            if (tick) begin
                frame_o <= frame_o + 8'd1;
                if (!pause_i) begin
                    offset_q <= offset_q + Step;
                end
            end
        end
    end

    // Bouncing box
    logic box_hit_d;

`ifdef VGA_PATTERN_ANIM_BOX_EN
    localparam logic [9:0] BoxXMax = 10'(H_VISIBLE - 16);
    localparam logic [9:0] BoxYMax = 10'(V_VISIBLE - 16);

    logic [9:0] box_x_q;
    logic [9:0] box_y_q;
    logic       dir_x_q;  // 1: moving +
    logic       dir_y_q;
    logic [9:0] box_dx;
    logic [9:0] box_dy;

    // Modular subtraction: a pixel left of or above the box wraps to a large
    // value, so one unsigned compare per axis covers both sides.
    assign box_dx    = column_i - box_x_q;
    assign box_dy    = row_i - box_y_q;
    assign box_hit_d = (box_dx < 10'd16) && (box_dy < 10'd16);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            box_x_q <= 10'd0;
            box_y_q <= 10'd0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else if (tick && !pause_i) begin
            if (dir_x_q) begin
                if (box_x_q == BoxXMax) begin
                    dir_x_q <= 1'b0;
                    box_x_q <= box_x_q - 10'd1;
                end else begin
                    box_x_q <= box_x_q + 10'd1;
                end
            end else begin
                if (box_x_q == 10'd0) begin
                    dir_x_q <= 1'b1;
                    box_x_q <= box_x_q + 10'd1;
                end else begin
                    box_x_q <= box_x_q - 10'd1;
                end
            end

            if (dir_y_q) begin
                if (box_y_q == BoxYMax) begin
                    dir_y_q <= 1'b0;
                    box_y_q <= box_y_q - 10'd1;
                end else begin
                    box_y_q <= box_y_q + 10'd1;
                end
            end else begin
                if (box_y_q == 10'd0) begin
                    dir_y_q <= 1'b1;
                    box_y_q <= box_y_q + 10'd1;
                end else begin
                    box_y_q <= box_y_q - 10'd1;
                end
            end
        end
    end
`else
    assign box_hit_d = 1'b0;
`endif

    // Pipeline stage 1
    logic [2:0] bar_d;
    logic       border_d;

    // The bar index is bits [8:6] of (column + offset) mod 1024.
    assign bar_d    = 3'((column_i + offset_q) >> 6);
    assign border_d = (column_i == 10'd0) || (column_i == ColLast) ||
                      (row_i == 10'd0) || (row_i == RowLast);

    logic [2:0] bar_q;
    logic       border_q;
    logic       box_hit_q;
    logic       vis1_q;
    logic       hs1_q;
    logic       vs1_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bar_q     <= 3'd0;
            border_q  <= 1'b0;
            box_hit_q <= 1'b0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
        end else begin
            bar_q     <= bar_d;
            border_q  <= border_d;
            box_hit_q <= box_hit_d;
            vis1_q    <= visible_i;
            hs1_q     <= hsync_i;
            vs1_q     <= vsync_i;
        end
    end

    // Pipeline stage 2: registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            red_o     <= 4'h0;
            green_o   <= 4'h0;
            blue_o    <= 4'h0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            visible_o <= 1'b0;
        end else begin
            hsync_o   <= hs1_q;
            vsync_o   <= vs1_q;
            visible_o <= vis1_q;
            if (!vis1_q) begin
                red_o   <= 4'h0;
                green_o <= 4'h0;
                blue_o  <= 4'h0;
            end else if (border_q) begin
                red_o   <= 4'hF;
                green_o <= 4'hF;
                blue_o  <= 4'hF;
            end else if (box_hit_q) begin
                red_o   <= 4'hF;
                green_o <= 4'hF;
                blue_o  <= 4'h0;
            end else begin
                red_o   <= {4{bar_q[0]}};
                green_o <= {4{bar_q[1]}};
                blue_o  <= {4{bar_q[2]}};
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_anim.sv
module tb_vga_pattern_anim;

    logic       clk;
    logic       reset;
    logic       pause;
    logic       visible;
    logic       hsync;
    logic       vsync;
    logic [9:0] column;
    logic [9:0] row;

    logic [3:0] red_a, green_a, blue_a;
    logic       hsync_a, vsync_a, visible_a;
    logic [7:0] frame_a;

    logic [3:0] red_b, green_b, blue_b;
    logic       hsync_b, vsync_b, visible_b;
    logic [7:0] frame_b;

    int checks;
    int errors;

    // dut scrolls 1 px per frame; dut63 scrolls 63 px per frame
    vga_pattern_anim #(
        .H_VISIBLE(640),
        .V_VISIBLE(480),
        .SPEED    (1)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .pause_i  (pause),
        .visible_i(visible),
        .hsync_i  (hsync),
        .vsync_i  (vsync),
        .column_i (column),
        .row_i    (row),
        .red_o    (red_a),
        .green_o  (green_a),
        .blue_o   (blue_a),
        .hsync_o  (hsync_a),
        .vsync_o  (vsync_a),
        .visible_o(visible_a),
        .frame_o  (frame_a)
    );

    vga_pattern_anim #(
        .H_VISIBLE(640),
        .V_VISIBLE(480),
        .SPEED    (63)
    ) dut63 (
        .clk_i    (clk),
        .reset_i  (reset),
        .pause_i  (pause),
        .visible_i(visible),
        .hsync_i  (hsync),
        .vsync_i  (vsync),
        .column_i (column),
        .row_i    (row),
        .red_o    (red_b),
        .green_o  (green_b),
        .blue_o   (blue_b),
        .hsync_o  (hsync_b),
        .vsync_o  (vsync_b),
        .visible_o(visible_b),
        .frame_o  (frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb_a();
        return {red_a, green_a, blue_a};
    endfunction

    function automatic logic [11:0] rgb_b();
        return {red_b, green_b, blue_b};
    endfunction

    task automatic idle_inputs();
        visible = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        column  = 10'd0;
        row     = 10'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold one pixel long enough for it to reach the outputs, sample at negedge
    task automatic pixel(input logic vis, input int col, input int r);
        @(negedge clk);
        visible = vis;
        column  = 10'(col);
        row     = 10'(r);
        @(negedge clk);
        @(negedge clk);
    endtask

    // One vsync falling edge, with visible low as in vertical blanking
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            visible = 1'b0;
            vsync   = 1'b0;
            @(negedge clk);
            vsync   = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pause  = 1'b0;
        idle_inputs();

        // Reset state, sampled while reset is still held
        @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("reset_rgb", 32'(rgb_a()), 32'h000);
        check_eq("reset_hsync", 32'(hsync_a), 32'd1);
        check_eq("reset_vsync", 32'(vsync_a), 32'd1);
        check_eq("reset_visible", 32'(visible_a), 32'd0);
        check_eq("reset_frame", 32'(frame_a), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Latency: pixel and sync must appear together exactly 2 cycles later
        visible = 1'b1;
        hsync   = 1'b0;
        column  = 10'd100;
        row     = 10'd100;
        @(negedge clk);
        idle_inputs();
        check_eq("lat1_visible", 32'(visible_a), 32'd0);
        check_eq("lat1_hsync", 32'(hsync_a), 32'd1);
        check_eq("lat1_rgb", 32'(rgb_a()), 32'h000);
        @(negedge clk);
        check_eq("lat2_visible", 32'(visible_a), 32'd1);
        check_eq("lat2_hsync", 32'(hsync_a), 32'd0);
        check_eq("lat2_rgb", 32'(rgb_a()), 32'hF00);
        @(negedge clk);
        check_eq("lat3_rgb", 32'(rgb_a()), 32'h000);
        check_eq("lat3_hsync", 32'(hsync_a), 32'd1);

        // Static bars, border and blanking with offset 0
        pixel(1'b1, 100, 100);
        check_eq("bar1_a", 32'(rgb_a()), 32'hF00);
        check_eq("bar1_b", 32'(rgb_b()), 32'hF00);
        pixel(1'b1, 200, 100);  // bar 3
        check_eq("bar3", 32'(rgb_a()), 32'hFF0);
        pixel(1'b1, 450, 100);  // bar 7
        check_eq("bar7", 32'(rgb_a()), 32'hFFF);
        pixel(1'b1, 300, 100);  // bar 4
        check_eq("bar4", 32'(rgb_a()), 32'h00F);
        pixel(1'b1, 0, 100);
        check_eq("border_left", 32'(rgb_a()), 32'hFFF);
        pixel(1'b1, 639, 5);
        check_eq("border_right", 32'(rgb_a()), 32'hFFF);
        pixel(1'b1, 100, 0);
        check_eq("border_top", 32'(rgb_a()), 32'hFFF);
        pixel(1'b1, 100, 479);
        check_eq("border_bottom", 32'(rgb_a()), 32'hFFF);
        pixel(1'b0, 100, 100);
        check_eq("blank", 32'(rgb_a()), 32'h000);

        // Scroll: three ticks take the offset to 3 (dut) and 189 (dut63)
        ticks(3);
        check_eq("frame3", 32'(frame_a), 32'd3);
        check_eq("vsync_idle", 32'(vsync_a), 32'd1);
        pixel(1'b1, 61, 100);   // 64 -> bar 1
        check_eq("scroll_61", 32'(rgb_a()), 32'hF00);
        check_eq("scroll63_61", 32'(rgb_b()), 32'hFF0);  // 250 -> bar 3
        pixel(1'b1, 60, 100);   // 63 -> bar 0
        check_eq("scroll_60", 32'(rgb_a()), 32'h000);

        // Pause: frame counter keeps going, offset holds
        @(negedge clk);
        pause = 1'b1;
        ticks(2);
        @(negedge clk);
        pause = 1'b0;
        check_eq("pause_frame", 32'(frame_a), 32'd5);
        pixel(1'b1, 60, 100);
        check_eq("pause_60", 32'(rgb_a()), 32'h000);
        pixel(1'b1, 61, 100);
        check_eq("pause_61", 32'(rgb_a()), 32'hF00);
        check_eq("pause63_61", 32'(rgb_b()), 32'hFF0);

        // Reset mid-stream brings offset and frame back to 0
        do_reset();
        @(negedge clk);
        check_eq("rst2_frame", 32'(frame_a), 32'd0);
        pixel(1'b1, 61, 100);   // offset 0 -> bar 0
        check_eq("rst2_61", 32'(rgb_a()), 32'h000);

        // Wrap: 17 ticks at 63 px gives 1071 mod 1024 = 47
        ticks(17);
        check_eq("frame17", 32'(frame_b), 32'd17);
        pixel(1'b1, 17, 100);   // 64 -> bar 1
        check_eq("wrap63_17", 32'(rgb_b()), 32'hF00);
        pixel(1'b1, 16, 100);   // 63 -> bar 0
        check_eq("wrap63_16", 32'(rgb_b()), 32'h000);
        pixel(1'b1, 47, 100);   // dut offset 17 -> 64
        check_eq("off17_47", 32'(rgb_a()), 32'hF00);

        ticks(238);
        check_eq("frame255", 32'(frame_a), 32'd255);
        ticks(1);
        check_eq("frame_wrap", 32'(frame_a), 32'd0);

`ifdef VGA_PATTERN_ANIM_BOX_EN
        // 624 ticks from reset: box at (624, 304), dut63 offset 400
        do_reset();
        ticks(624);
        check_eq("box_frame", 32'(frame_b), 32'd112);
        pixel(1'b1, 630, 310);
        check_eq("box_hit", 32'(rgb_b()), 32'hFF0);
        pixel(1'b1, 630, 330);  // below the box: 1030 mod 1024 -> bar 0
        check_eq("box_miss", 32'(rgb_b()), 32'h000);
        // Next tick bounces: box at (623, 303), offset 463
        ticks(1);
        pixel(1'b1, 623, 310);
        check_eq("box_bounce_edge", 32'(rgb_b()), 32'hFF0);
        pixel(1'b1, 622, 310);  // 1085 mod 1024 -> bar 0
        check_eq("box_bounce_left", 32'(rgb_b()), 32'h000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
